bcd_time_counter: RTL and testbench

Free-running BCD time-of-day counter. It accepts a full time word from the time-set stage, advances it in hundredths of a second, and drives the 32-bit packed BCD time consumed by the seven-segment driver. It is the single owner of the current time in the clock core.

---
 rtl/bcd_time_pkg.sv | 37 +++
 rtl/bcd_digit_pair.sv | 48 ++++
 rtl/bcd_time_counter.sv | 184 ++++++++++++++++++
 tb/tb_bcd_time_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_time_pkg.sv
// Shared constants and types for the BCD time-of-day counter.
// Field layout of the packed time word: [31:24] HH, [23:16] MM, [15:8] SS, [7:0] CC.
package bcd_time_pkg;

    localparam int HH_LSB = 24;
    localparam int MM_LSB = 16;
    localparam int SS_LSB = 8;
    localparam int CC_LSB = 0;

    localparam logic [7:0] CC_MAX     = 8'h99;
    localparam logic [7:0] SS_MAX     = 8'h59;
    localparam logic [7:0] MM_MAX     = 8'h59;
    localparam logic [7:0] HH_MAX_24  = 8'h23;
    localparam logic [7:0] HH_WRAP_24 = 8'h00;
    localparam logic [7:0] HH_MAX_12  = 8'h12;
    localparam logic [7:0] HH_WRAP_12 = 8'h01;
    // Hour value whose increment flips AM/PM in 12-hour mode (11 -> 12).
    localparam logic [7:0] HH_MERIDIEM = 8'h11;

    localparam logic [31:0] RST_TIME_24 = 32'h0000_0000;
    localparam logic [31:0] RST_TIME_12 = 32'h1200_0000;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_e;

    // A two-digit BCD field is acceptable when both digits are decimal,
    // the tens digit is within range and the whole field does not exceed max_val.
    // With decimal digits, packed BCD orders the same way as its numeric value.
    function automatic logic field_ok(input logic [7:0] f,
                                      input logic [3:0] tens_max,
                                      input logic [7:0] max_val);
        return (f[3:0] <= 4'd9) && (f[7:4] <= tens_max) && (f <= max_val);
    endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD counter: synchronous load, increment enable, programmable
// maximum and wrap-to value; carry is high on the increment that wraps.
module bcd_digit_pair
    import bcd_time_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    input  logic [7:0] max_val,
    input  logic [7:0] wrap_val,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] value_q;
    logic [7:0] value_inc;

    // Next value on increment: wrap at the maximum, else decimal-adjusted +1.
    always_comb begin
        value_inc = value_q;
        if (value_q == max_val) begin
            value_inc = wrap_val;
        end else if (value_q[3:0] == 4'd9) begin
            value_inc = {value_q[7:4] + 4'd1, 4'd0};
        end else begin
            value_inc = {value_q[7:4], value_q[3:0] + 4'd1};
        end
    end

    // Field register: load has priority over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= RST_VAL;
        end else if (load) begin
            value_q <= load_val;
        end else if (inc) begin
            value_q <= value_inc;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == max_val);

endmodule

// File: rtl/bcd_time_counter.sv
// Free-running BCD time-of-day counter advancing in hundredths of a second.
// Optional 12-hour mode with a pm output: define BCD_TIME_TWELVE_HOUR_EN.
//
// state   | meaning
// STOPPED | run was low last cycle: time and prescaler held
// RUNNING | run was high last cycle: prescaler counts, time advances on wrap
module bcd_time_counter
    import bcd_time_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        load_valid,
    input  logic [31:0] load_time,
    output logic [31:0] time_bcd,
    output logic        tick,
    output logic        rollover,
    output logic        load_err
`ifdef BCD_TIME_TWELVE_HOUR_EN
    ,
    output logic        pm
`endif
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

`ifdef BCD_TIME_TWELVE_HOUR_EN
    localparam logic [31:0] RST_TIME = RST_TIME_12;
    localparam logic [7:0]  HH_MAX   = HH_MAX_12;
    localparam logic [7:0]  HH_WRAP  = HH_WRAP_12;
`else
    localparam logic [31:0] RST_TIME = RST_TIME_24;
    localparam logic [7:0]  HH_MAX   = HH_MAX_24;
    localparam logic [7:0]  HH_WRAP  = HH_WRAP_24;
`endif

    run_state_e    state_q, state_d;
    logic [PW-1:0] presc_q;
    logic          fields_ok;
    logic          load_ok;
    logic          load_bad;
    logic          wrap;
    logic          advance;
    logic          roll_d;
    logic          cc_carry, ss_carry, mm_carry, hh_carry;

    wire [7:0] ld_hh = load_time[HH_LSB +: 8];
    wire [7:0] ld_mm = load_time[MM_LSB +: 8];
    wire [7:0] ld_ss = load_time[SS_LSB +: 8];
    wire [7:0] ld_cc = load_time[CC_LSB +: 8];

    // Run state register; follows run one cycle late.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control: load validation, prescaler wrap, advance.
    always_comb begin
        state_d   = run ? RUNNING : STOPPED;
        fields_ok = field_ok(ld_cc, 4'd9, CC_MAX) &&
                    field_ok(ld_ss, 4'd5, SS_MAX) &&
                    field_ok(ld_mm, 4'd5, MM_MAX);
`ifdef BCD_TIME_TWELVE_HOUR_EN
        fields_ok = fields_ok && field_ok(ld_hh, 4'd1, HH_MAX_12) && (ld_hh != 8'h00);
`else
        fields_ok = fields_ok && field_ok(ld_hh, 4'd2, HH_MAX_24);
`endif
        load_ok  = load_valid && fields_ok;
        load_bad = load_valid && !fields_ok;
        wrap     = (state_q == RUNNING) && (presc_q == PRESC_LAST);
        // A valid load in the wrap cycle replaces the advance entirely.
        advance  = wrap && !load_ok;
    end

    // Prescaler: cleared by a valid load, counts only while running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (load_ok) begin
            presc_q <= '0;
        end else if (state_q == RUNNING) begin
            presc_q <= wrap ? '0 : presc_q + PW'(1);
        end
    end

    bcd_digit_pair #(.RST_VAL(RST_TIME[CC_LSB +: 8])) u_cc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_ok),
        .load_val (ld_cc),
        .inc      (advance),
        .max_val  (CC_MAX),
        .wrap_val (8'h00),
        .value    (time_bcd[CC_LSB +: 8]),
        .carry    (cc_carry)
    );

    bcd_digit_pair #(.RST_VAL(RST_TIME[SS_LSB +: 8])) u_ss (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_ok),
        .load_val (ld_ss),
        .inc      (cc_carry),
        .max_val  (SS_MAX),
        .wrap_val (8'h00),
        .value    (time_bcd[SS_LSB +: 8]),
        .carry    (ss_carry)
    );

    bcd_digit_pair #(.RST_VAL(RST_TIME[MM_LSB +: 8])) u_mm (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_ok),
        .load_val (ld_mm),
        .inc      (ss_carry),
        .max_val  (MM_MAX),
        .wrap_val (8'h00),
        .value    (time_bcd[MM_LSB +: 8]),
        .carry    (mm_carry)
    );

    bcd_digit_pair #(.RST_VAL(RST_TIME[HH_LSB +: 8])) u_hh (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_ok),
        .load_val (ld_hh),
        .inc      (mm_carry),
        .max_val  (HH_MAX),
        .wrap_val (HH_WRAP),
        .value    (time_bcd[HH_LSB +: 8]),
        .carry    (hh_carry)
    );

`ifdef BCD_TIME_TWELVE_HOUR_EN
    logic pm_q;
    logic meridiem_flip;

    // In 12-hour mode midnight is the 11 -> 12 step taken while in PM;
    // the 12 -> 01 hour wrap is an ordinary step.
    always_comb begin
        meridiem_flip = mm_carry && (time_bcd[HH_LSB +: 8] == HH_MERIDIEM);
        roll_d        = meridiem_flip && pm_q && !hh_carry;
    end

    // AM/PM flag; loads leave it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pm_q <= 1'b0;
        end else if (meridiem_flip) begin
            pm_q <= !pm_q;
        end
    end

    assign pm = pm_q;
`else
    // 24-hour mode: midnight is the hour field wrapping 23 -> 00.
    always_comb begin
        roll_d = hh_carry;
    end
`endif

    // Registered single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick     <= 1'b0;
            rollover <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick     <= advance;
            rollover <= roll_d;
            load_err <= load_bad;
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter (24-hour build, DIV = 4). A reference model keeps
// the time as a plain count of hundredths since midnight; a compare process
// checks every output against it each cycle, and the stimulus adds literal checks.
module tb_bcd_time_counter;

    localparam int CLK_HZ  = 400;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int DAY     = 24 * 60 * 60 * 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_time = 32'h0;
    logic [31:0] time_bcd;
    logic        tick;
    logic        rollover;
    logic        load_err;
`ifdef BCD_TIME_TWELVE_HOUR_EN
    logic        pm;
`endif

    int checks = 0;
    int errors = 0;

    bcd_time_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .load_valid (load_valid),
        .load_time  (load_time),
        .time_bcd   (time_bcd),
        .tick       (tick),
        .rollover   (rollover),
        .load_err   (load_err)
`ifdef BCD_TIME_TWELVE_HOUR_EN
        ,
        .pm         (pm)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int t);
        int h, m, s, c;
        c = t % 100;
        s = (t / 100) % 60;
        m = (t / 6000) % 60;
        h = t / 360000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic int digit(input logic [31:0] v, input int i);
        logic [31:0] sh;
        sh = v >> (4 * i);
        return int'(sh[3:0]);
    endfunction

    function automatic bit time_ok(input logic [31:0] v);
        for (int i = 0; i < 8; i++) begin
            if (digit(v, i) > 9) return 1'b0;
        end
        return (digit(v, 7) * 10 + digit(v, 6) < 24) &&
               (digit(v, 5) * 10 + digit(v, 4) < 60) &&
               (digit(v, 3) * 10 + digit(v, 2) < 60);
    endfunction

    function automatic int from_bcd(input logic [31:0] v);
        return (digit(v, 7) * 10 + digit(v, 6)) * 360000 +
               (digit(v, 5) * 10 + digit(v, 4)) * 6000 +
               (digit(v, 3) * 10 + digit(v, 2)) * 100 +
               (digit(v, 1) * 10 + digit(v, 0));
    endfunction

    // Reference model state, updated at each rising edge.
    int m_t = 0;
    int m_presc = 0;
    bit m_run = 0;
    bit m_tick = 0;
    bit m_roll = 0;
    bit m_err = 0;
    bit m_known = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_t = 0; m_presc = 0; m_run = 0;
            m_tick = 0; m_roll = 0; m_err = 0;
            m_known = 1;
        end else begin
            m_tick = 0; m_roll = 0; m_err = 0;
            if (load_valid && time_ok(load_time)) begin
                m_t = from_bcd(load_time);
                m_presc = 0;
            end else begin
                if (load_valid) m_err = 1;
                if (m_run) begin
                    if (m_presc == DIV - 1) begin
                        m_presc = 0;
                        m_t = (m_t + 1) % DAY;
                        m_tick = 1;
                        m_roll = (m_t == 0);
                    end else begin
                        m_presc++;
                    end
                end
            end
            m_run = run;
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("model_time", time_bcd, to_bcd(m_t));
            check("model_tick", {31'b0, tick}, {31'b0, m_tick});
            check("model_rollover", {31'b0, rollover}, {31'b0, m_roll});
            check("model_load_err", {31'b0, load_err}, {31'b0, m_err});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tick !== 1'b1 && waited < limit);
        if (tick !== 1'b1) check("tick_timeout", {31'b0, tick}, 32'd1);
    endtask

    task automatic do_load(input logic [31:0] v);
        load_time  = v;
        load_valid = 1'b1;
        cyc(1);
        load_valid = 1'b0;
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        cyc(3);
        check("reset_time", time_bcd, 32'h0000_0000);
        check("reset_tick", {31'b0, tick}, 32'd0);

        // Release and run: first tick 5 cycles later (1 state delay + DIV).
        rst_n = 1'b1;
        run   = 1'b1;
        wait_tick(20, w);
        check("first_tick_latency", w, 32'd5);
        check("first_tick_time", time_bcd, 32'h0000_0001);
        wait_tick(20, w);
        check("tick_period", w, 32'd4);
        check("second_tick_time", time_bcd, 32'h0000_0002);

        do_load(32'h0000_5999);
        check("load_visible", time_bcd, 32'h0000_5999);
        wait_tick(20, w);
        check("minute_carry", time_bcd, 32'h0001_0000);
        check("minute_carry_roll", {31'b0, rollover}, 32'd0);

        do_load(32'h2359_5999);
        wait_tick(20, w);
        check("midnight_time", time_bcd, 32'h0000_0000);
        check("midnight_roll", {31'b0, rollover}, 32'd1);

        // Stop, then reject out-of-range loads.
        run = 1'b0;
        cyc(2);
        do_load(32'h2400_0000);
        check("bad_hh_err", {31'b0, load_err}, 32'd1);
        check("bad_hh_time", time_bcd, 32'h0000_0000);
        cyc(1);
        check("bad_hh_err_cleared", {31'b0, load_err}, 32'd0);
        do_load(32'h0A00_0000);
        check("bad_nibble_err", {31'b0, load_err}, 32'd1);
        check("bad_nibble_time", time_bcd, 32'h0000_0000);
        do_load(32'h0000_6000);
        check("bad_ss_err", {31'b0, load_err}, 32'd1);

        // Load landing exactly on a prescaler wrap.
        run = 1'b1;
        w = 0;
        while (!(m_run && m_presc == DIV - 1) && w < 20) begin
            cyc(1);
            w++;
        end
        if (!(m_run && m_presc == DIV - 1)) check("wrap_align_timeout", 32'd0, 32'd1);
        do_load(32'h1020_3040);
        check("coincident_load_time", time_bcd, 32'h1020_3040);
        check("coincident_load_tick", {31'b0, tick}, 32'd0);
        wait_tick(20, w);
        check("after_load_period", w, 32'd4);
        check("after_load_time", time_bcd, 32'h1020_3041);

        // Freeze mid-count, then resume.
        cyc(2);
        run = 1'b0;
        cyc(10);
        check("frozen_time", time_bcd, 32'h1020_3041);
        run = 1'b1;
        wait_tick(20, w);
        check("resumed_time", time_bcd, 32'h1020_3042);

        // Carry all the way into the hour tens digit.
        do_load(32'h0959_5999);
        wait_tick(20, w);
        check("hour_tens_carry", time_bcd, 32'h1000_0000);

        // Reset beats a simultaneous load.
        rst_n = 1'b0;
        load_time = 32'h1111_1111;
        load_valid = 1'b1;
        cyc(1);
        check("reset_priority", time_bcd, 32'h0000_0000);
        rst_n = 1'b1;
        load_valid = 1'b0;
        run = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule
